credit_rr_arb: RTL

CREDIT_RR_ARB -- requirements
Module: credit_rr_arb

---
 rtl/credit_rr_arb.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/credit_rr_arb.sv
// Round-robin arbiter drawing grants from a shared downstream credit pool.
// The pool can be resized on the fly; resizing drains outstanding credits through FLUSH first.
module credit_rr_arb #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned BW   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_credits,
    input  logic [BW-1:0]   init_credits,
    input  logic [NREQ-1:0] req,
    input  logic            credit_return,
    output logic [NREQ-1:0] grant,
    output logic [BW-1:0]   credits_avail,
    output logic            no_credits,
    output logic            flushing,
    output logic            err_overflow
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        ST_UNINIT = 2'd0,
        ST_RUN    = 2'd1,
        ST_FLUSH  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [BW-1:0]   max_credit_q, max_credit_d;
    logic [BW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   pending_q, pending_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            err_q, err_d;

    logic [NREQ-1:0] grant_c;
    logic            grant_en;
    logic            gnt_any;
    logic [PW-1:0]   win_idx;
    logic            at_max;
    logic            ret_ok;
    logic [BW-1:0]   pend_eff;

    // Round-robin pick: first set request at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        int idx;
        idx      = 0;
        grant_c  = '0;
        gnt_any  = 1'b0;
        win_idx  = '0;
        grant_en = (state_q == ST_RUN) && (cnt_q != '0) && !load_credits;
        for (int o = 0; o < int'(NREQ); o++) begin
            idx = int'(rr_ptr_q) + o;
            if (idx >= int'(NREQ)) begin
                idx = idx - int'(NREQ);
            end
            if (grant_en && !gnt_any && req[PW'(idx)]) begin
                gnt_any = 1'b1;
                win_idx = PW'(idx);
            end
        end
        if (gnt_any) begin
            grant_c[win_idx] = 1'b1;
        end
    end

    // Next-state, credit accounting and pointer update.
    always_comb begin
        state_d      = state_q;
        max_credit_d = max_credit_q;
        cnt_d        = cnt_q;
        pending_d    = pending_q;
        rr_ptr_d     = rr_ptr_q;
        err_d        = err_q;
        pend_eff     = pending_q;

        at_max = (cnt_q == max_credit_q);
        ret_ok = credit_return && !at_max;

        if (credit_return && at_max) begin
            err_d = 1'b1;
        end

        if (gnt_any) begin
            rr_ptr_d = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
        end

        case (state_q)
            ST_UNINIT: begin
                if (load_credits && (init_credits != '0)) begin
                    max_credit_d = init_credits;
                    cnt_d        = init_credits;
                    state_d      = ST_RUN;
                end
            end
            ST_RUN: begin
                if (gnt_any && !ret_ok) begin
                    cnt_d = cnt_q - BW'(1);
                end else if (ret_ok && !gnt_any) begin
                    cnt_d = cnt_q + BW'(1);
                end
                if (load_credits) begin
                    pending_d = init_credits;
                    state_d   = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // A load arriving in the completing cycle wins over the older pending size.
                pend_eff  = load_credits ? init_credits : pending_q;
                pending_d = pend_eff;
                if (ret_ok) begin
                    cnt_d = cnt_q + BW'(1);
                end
                if (at_max) begin
                    max_credit_d = pend_eff;
                    cnt_d        = pend_eff;
                    state_d      = (pend_eff != '0) ? ST_RUN : ST_UNINIT;
                end
            end
            default: begin
                state_d = ST_UNINIT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_UNINIT;
            max_credit_q <= '0;
            cnt_q        <= '0;
            pending_q    <= '0;
            rr_ptr_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            max_credit_q <= max_credit_d;
            cnt_q        <= cnt_d;
            pending_q    <= pending_d;
            rr_ptr_q     <= rr_ptr_d;
            err_q        <= err_d;
        end
    end

    assign grant         = grant_c;
    assign credits_avail = cnt_q;
    assign no_credits    = (cnt_q == '0);
    assign flushing      = (state_q == ST_FLUSH);
    assign err_overflow  = err_q;

    a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_c));
    a_cnt_bounded:  assert property (@(posedge clk) disable iff (rst) cnt_q <= max_credit_q);

endmodule
